// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the switch debouncer bank.
package debounce_pkg;

    localparam int DEBOUNCE_LIMIT_DEFAULT = 250000;
    localparam int SYNC_STAGES            = 2;

    // Counter must hold values up to limit-1; never narrower than one bit.
    function automatic int cnt_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: synchroniser, stability counter, level register and
// optional registered edge pulses (built only with DEBOUNCE_EDGE_PULSE_EN).
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT,
    parameter logic RESET_STATE    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_raw,
    output logic sw_level,
`ifdef DEBOUNCE_EDGE_PULSE_EN
    output logic accept,
`endif
    output logic rise,
    output logic fall
);

    localparam int            CW   = cnt_width(DEBOUNCE_LIMIT);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LIMIT - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   state;
    logic                   synced;

`ifndef DEBOUNCE_EDGE_PULSE_EN
    logic accept;
`endif

    assign synced   = sync[SYNC_STAGES-1];
    // The new level is taken on the cycle the counter would otherwise reach LIMIT.
    assign accept   = (synced != state) && (cnt == LAST);
    assign sw_level = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= {SYNC_STAGES{RESET_STATE}};
            cnt   <= '0;
            state <= RESET_STATE;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], sw_raw};
            if (synced == state) begin
                cnt <= '0;
            end else if (accept) begin
                state <= synced;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef DEBOUNCE_EDGE_PULSE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= accept & synced;
            fall <= accept & ~synced;
        end
    end
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// NUM_CH independent switch debouncers with per-channel edge pulses and a
// combined change flag; edge logic exists only with DEBOUNCE_EDGE_PULSE_EN.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int   NUM_CH         = 4,
    parameter int   DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT,
    parameter logic RESET_STATE    = 1'b0
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [NUM_CH-1:0] i_Switch,
    output logic [NUM_CH-1:0] o_Switch,
    output logic [NUM_CH-1:0] o_Rise,
    output logic [NUM_CH-1:0] o_Fall,
    output logic              o_Changed
);

`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic [NUM_CH-1:0] accept;
`endif

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
            .RESET_STATE    (RESET_STATE)
        ) u_channel (
            .clk      (i_Clk),
            .rst      (i_Rst),
            .sw_raw   (i_Switch[ch]),
            .sw_level (o_Switch[ch]),
`ifdef DEBOUNCE_EDGE_PULSE_EN
            .accept   (accept[ch]),
`endif
            .rise     (o_Rise[ch]),
            .fall     (o_Fall[ch])
        );
    end

`ifdef DEBOUNCE_EDGE_PULSE_EN
    // Registered from the same accept terms as the edge pulses so it lines up with them.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_Changed <= 1'b0;
        end else begin
            o_Changed <= |accept;
        end
    end
`else
    assign o_Changed = 1'b0;
`endif

endmodule
